// File: rtl/mc_mem_port.sv
// Memory-side stage of the multi-cycle datapath: runs one word access on a
// req/ready external bus and holds the Instruction and Memory Data Registers.
module mc_mem_port #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ir_write,
  input  logic              iord,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              err,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_ready,
  input  logic [DATA_W-1:0] ext_rdata
);

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
  logic [DATA_W-1:0] ext_wdata_q, ext_wdata_d;
  logic              ext_we_q, ext_we_d;
  logic              irw_q, irw_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [ADDR_W-1:0] addr_sel;
  logic              any_strobe;
  logic              one_strobe;

  assign addr_sel   = iord ? alu_out : pc;
  assign any_strobe = mem_read | mem_write;
  assign one_strobe = mem_read ^ mem_write;

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    mdr_d       = mdr_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    ext_we_d    = ext_we_q;
    irw_d       = irw_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read & mem_write) begin
          err_d = 1'b1;
        end else if (one_strobe) begin
          if (addr_sel[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else begin
            ext_addr_d  = addr_sel;
            ext_wdata_d = wdata;
            ext_we_d    = mem_write;
            irw_d       = ir_write;
            cnt_d       = 8'd0;
            state_d     = ACCESS;
          end
        end
      end
      ACCESS: begin
        // A new strobe mid-access is flagged and dropped; the access carries on.
        if (any_strobe) err_d = 1'b1;
        if (ext_ready) begin
          if (!ext_we_q) begin
            if (irw_q) ir_d  = ext_rdata;
            else       mdr_d = ext_rdata;
          end
          state_d = IDLE;
        end else if (cnt_q == LAST_WAIT) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      mdr_q       <= '0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      ext_we_q    <= 1'b0;
      irw_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      ext_we_q    <= ext_we_d;
      irw_q       <= irw_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Request/busy decode straight from state so reset drops them at once.
  assign busy      = (state_q == ACCESS);
  assign ext_req   = (state_q == ACCESS);
  assign ext_we    = ext_we_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;
  assign ir_out    = ir_q;
  assign mdr_out   = mdr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mc_mem_port.sv
// Directed plus randomized bench for mc_mem_port; expected IR/MDR values come
// from a transaction-level model updated only on completed reads.
module tb_mc_mem_port;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_read, mem_write, ir_write, iord;
  logic [AW-1:0] pc, alu_out, ext_addr;
  logic [DW-1:0] wdata, ir_out, mdr_out, ext_wdata, ext_rdata;
  logic          busy, err, ext_req, ext_we, ext_ready;

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] ir_m, mdr_m;

  mc_mem_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .iord(iord), .pc(pc), .alu_out(alu_out), .wdata(wdata),
    .ir_out(ir_out), .mdr_out(mdr_out), .busy(busy), .err(err),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ready(ext_ready), .ext_rdata(ext_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input bit rd, input bit wr, input bit irw, input bit sel,
                         input logic [31:0] addr, input logic [31:0] data);
    iord = sel; ir_write = irw; wdata = data; mem_read = rd; mem_write = wr;
    if (sel) begin alu_out = addr; pc = $urandom(); end
    else     begin pc = addr; alu_out = $urandom(); end
  endtask

  task automatic check_idle_regs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_req"},  ext_req, 0);
    check({tag, "_ir"},   ir_out, ir_m);
    check({tag, "_mdr"},  mdr_out, mdr_m);
  endtask

  // Full aligned access: bus sees it the cycle after the strobe, ready after lat waits.
  task automatic access(input bit wr, input bit irw, input bit sel, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata, input int lat);
    present(!wr, wr, irw, sel, addr, data);
    cycle();
    mem_read = 0; mem_write = 0;
    check("acc_busy", busy, 1);
    check("acc_req",  ext_req, 1);
    check("acc_we",   ext_we, wr);
    check("acc_addr", ext_addr, addr);
    if (wr) check("acc_wdata", ext_wdata, data);
    check("acc_err",  err, 0);
    for (int i = 0; i < lat; i++) begin
      cycle();
      check("wait_req",  ext_req, 1);
      check("wait_addr", ext_addr, addr);
    end
    ext_ready = 1; ext_rdata = rdata;
    cycle();
    ext_ready = 0; ext_rdata = $urandom();
    if (!wr) begin
      if (irw) ir_m = rdata;
      else     mdr_m = rdata;
    end
    check_idle_regs("done");
    check("done_err", err, 0);
  endtask

  // Strobe that must be rejected in IDLE with a single err pulse and no bus activity.
  task automatic reject(input bit rd, input bit wr, input logic [31:0] addr);
    present(rd, wr, 1'b0, 1'b1, addr, $urandom());
    cycle();
    mem_read = 0; mem_write = 0;
    check("rej_err", err, 1);
    check_idle_regs("rej");
    cycle();
    check("rej_err_clr", err, 0);
    check("rej_req2", ext_req, 0);
  endtask

  initial begin
    int n;
    reset = 1; mem_read = 0; mem_write = 0; ir_write = 0; iord = 0;
    pc = 0; alu_out = 0; wdata = 0; ext_ready = 0; ext_rdata = 0;
    ir_m = 0; mdr_m = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_req",  ext_req, 0);
    check("rst_err",  err, 0);
    check("rst_we",   ext_we, 0);
    check("rst_addr", ext_addr, 0);
    check("rst_wd",   ext_wdata, 0);
    check("rst_ir",   ir_out, 0);
    check("rst_mdr",  mdr_out, 0);
    @(negedge clk); @(negedge clk);
    reset = 0;

    // Fetch, then an MDR load that must leave IR alone
    access(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h8C08_0004, 3);
    access(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 32'h1234_5678, 1);
    // Store with wait-free ready
    access(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0);

    // Misaligned and conflicting strobes
    reject(1'b1, 1'b0, 32'h0000_0102);
    reject(1'b0, 1'b1, 32'h0000_0301);
    reject(1'b1, 1'b1, 32'h0000_0100);

    // Timeout: ext_req must stay up exactly TO cycles, then err with MDR untouched
    present(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'h0);
    cycle();
    mem_read = 0;
    n = 0;
    while (ext_req === 1'b1 && n < 40) begin
      n++;
      cycle();
    end
    check("to_cycles", n, TO);
    check("to_err", err, 1);
    check_idle_regs("to");
    cycle();
    check("to_err_clr", err, 0);

    // Overlap mid-access: err pulse, access still completes
    present(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0);
    cycle();
    mem_read = 1;
    cycle();
    mem_read = 0;
    check("ovl_err",  err, 1);
    check("ovl_busy", busy, 1);
    cycle();
    check("ovl_err_clr", err, 0);
    ext_ready = 1; ext_rdata = 32'hCAFE_0001;
    cycle();
    ext_ready = 0;
    mdr_m = 32'hCAFE_0001;
    check_idle_regs("ovl_done");

    // Overlap in the completion cycle: completion still lands
    present(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0048, 32'h0);
    cycle();
    mem_read = 0;
    mem_write = 1; ext_ready = 1; ext_rdata = 32'h2002_0003;
    cycle();
    mem_write = 0; ext_ready = 0;
    ir_m = 32'h2002_0003;
    check("ovc_err", err, 1);
    check_idle_regs("ovc");
    cycle();
    check("ovc_err_clr", err, 0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a = $urandom() & 32'hFFFF_FFFC;
      case (kind)
        0, 1, 2: access(1'b0, 1'b1, 1'($urandom_range(0, 1)), a, 32'h0, $urandom(), $urandom_range(0, 6));
        3, 4, 5: access(1'b0, 1'b0, 1'($urandom_range(0, 1)), a, 32'h0, $urandom(), $urandom_range(0, 6));
        6, 7:    access(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom(), $urandom(), $urandom_range(0, 6));
        8:       reject(1'b1, 1'b0, a | 32'($urandom_range(1, 3)));
        default: reject(1'b1, 1'b1, a);
      endcase
    end

    // Reset mid-access clears bus request and both data registers at once
    present(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    cycle();
    mem_read = 0;
    check("mid_busy", busy, 1);
    reset = 1;
    #1;
    ir_m = 0; mdr_m = 0;
    check_idle_regs("mid_rst");
    check("mid_rst_err", err, 0);
    @(negedge clk);
    reset = 0;
    cycle();
    check_idle_regs("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
